// File: rtl/draw_scheduler.sv
// Purpose: shares the framebuffer write port between three pixel requesters and a screen-clear engine.
// Latency: one cycle from grant to registered plot strobe; a full clear takes SCREEN_W*SCREEN_H cycles.
// Backpressure: a requester holds req until granted; clear_req and the clear engine stall all grants.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   clear_req             level request to start a full-screen clear (ignored while clearing)
//   req/req_x/req_y/req_col  three pixel requesters (0 tail-erase, 1 head, 2 food), packed slices
//   gnt                   one-hot combinational grant in the same cycle as req
//   clear_busy/clear_done clear engine owns the port / final clear pixel strobe
//   plot_x/plot_y/plot_col/plot  registered pixel write towards the VGA adapter
module draw_scheduler #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CLR_COL  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    input  logic [2:0]         req,
    input  logic [3*X_W-1:0]   req_x,
    input  logic [3*Y_W-1:0]   req_y,
    input  logic [3*COL_W-1:0] req_col,
    output logic [2:0]         gnt,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COL_W-1:0]   plot_col,
    output logic               plot
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [2:0]       gnt_int;
    logic             pick_vld;
    logic             last_pix;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [COL_W-1:0] pix_col;

    // Round-robin successor over the three requesters (ptr only ever holds 0..2).
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign last_pix = (state == CLEAR) &&
                      (cx == X_W'(SCREEN_W - 1)) &&
                      (cy == Y_W'(SCREEN_H - 1));

    always_comb begin
        logic [1:0] c0, c1, c2;
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_int    = 3'b000;
        pick_vld   = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        c0 = rr_next(ptr);
        c1 = rr_next(c0);
        c2 = ptr;

        case (state)
            ARB: begin
                // A clear request wins outright; pending pixel requests simply wait.
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (req != 3'b000) begin
                    pick_vld = 1'b1;
                    if (req[c0]) begin
                        gnt_int[c0] = 1'b1;
                        ptr_nxt     = c0;
                    end else if (req[c1]) begin
                        gnt_int[c1] = 1'b1;
                        ptr_nxt     = c1;
                    end else begin
                        gnt_int[c2] = 1'b1;
                        ptr_nxt     = c2;
                    end
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (last_pix) begin
                    clear_done = 1'b1;
                    state_nxt  = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase

        gnt = gnt_int;
        // Nothing is granted or reported while reset is being applied.
        if (rst) begin
            gnt        = 3'b000;
            clear_busy = 1'b0;
            clear_done = 1'b0;
        end
    end

    // Select the granted requester's pixel slice.
    always_comb begin
        pix_x   = '0;
        pix_y   = '0;
        pix_col = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_int[i]) begin
                pix_x   = req_x[i*X_W +: X_W];
                pix_y   = req_y[i*Y_W +: Y_W];
                pix_col = req_col[i*COL_W +: COL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= 2'd2;
            cx       <= '0;
            cy       <= '0;
            plot     <= 1'b0;
            plot_x   <= '0;
            plot_y   <= '0;
            plot_col <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            case (state)
                ARB: begin
                    if (clear_req) begin
                        cx   <= '0;
                        cy   <= '0;
                        plot <= 1'b0;
                    end else if (pick_vld) begin
                        plot     <= 1'b1;
                        plot_x   <= pix_x;
                        plot_y   <= pix_y;
                        plot_col <= pix_col;
                    end else begin
                        plot <= 1'b0;
                    end
                end
                CLEAR: begin
                    plot     <= 1'b1;
                    plot_x   <= cx;
                    plot_y   <= cy;
                    plot_col <= COL_W'(CLR_COL);
                    // Raster scan; both counters fall back to 0 after the last pixel.
                    if (cx == X_W'(SCREEN_W - 1)) begin
                        cx <= '0;
                        if (cy == Y_W'(SCREEN_H - 1)) begin
                            cy <= '0;
                        end else begin
                            cy <= cy + Y_W'(1);
                        end
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                default: plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Purpose: self-checking bench for draw_scheduler with an in-bench behavioural model.
// Latency: model predicts plot one cycle after grant; clear modelled as a pixel index 0..W*H-1.
// Backpressure: random requesters keep req/data stable until granted.
module tb_draw_scheduler;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int NPIX  = SW * SH;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear_req;
    logic [2:0]         req;
    logic [3*X_W-1:0]   req_x;
    logic [3*Y_W-1:0]   req_y;
    logic [3*COL_W-1:0] req_col;
    logic [2:0]         gnt;
    logic               clear_busy;
    logic               clear_done;
    logic [X_W-1:0]     plot_x;
    logic [Y_W-1:0]     plot_y;
    logic [COL_W-1:0]   plot_col;
    logic               plot;

    draw_scheduler #(
        .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W),
        .SCREEN_W(SW), .SCREEN_H(SH), .CLR_COL(0)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req(req), .req_x(req_x), .req_y(req_y), .req_col(req_col),
        .gnt(gnt), .clear_busy(clear_busy), .clear_done(clear_done),
        .plot_x(plot_x), .plot_y(plot_y), .plot_col(plot_col), .plot(plot)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_clear = 1'b0;  // clear in progress
    int         m_k     = 0;     // index of the next clear pixel, raster order
    int         m_ptr   = 2;     // last granted requester
    bit         ep      = 1'b0;  // expected plot strobe
    int         ex = 0, ey = 0, ec = 0;
    logic [2:0] m_gnt   = 3'b000;

    always @(negedge clk) begin
        logic [2:0] eg;
        bit         ebusy, edone;
        int         gi;
        eg = 3'b000; ebusy = 1'b0; edone = 1'b0; gi = -1;
        if (!rst) begin
            if (m_clear) begin
                ebusy = 1'b1;
                edone = (m_k == NPIX - 1);
            end else if (!clear_req) begin
                for (int off = 1; off <= 3; off++) begin
                    int i;
                    i = (m_ptr + off) % 3;
                    if (req[i] && gi < 0) gi = i;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
        end
        m_gnt = eg;

        check("gnt", {29'd0, gnt}, {29'd0, eg});
        check("clear_busy", {31'd0, clear_busy}, {31'd0, ebusy});
        check("clear_done", {31'd0, clear_done}, {31'd0, edone});
        check("plot", {31'd0, plot}, {31'd0, ep});
        if (ep) begin
            check("plot_x", {24'd0, plot_x}, ex);
            check("plot_y", {25'd0, plot_y}, ey);
            check("plot_col", {29'd0, plot_col}, ec);
        end

        if (rst) begin
            m_clear = 1'b0; m_k = 0; m_ptr = 2; ep = 1'b0;
        end else if (m_clear) begin
            ep = 1'b1; ex = m_k % SW; ey = m_k / SW; ec = 0;
            if (m_k == NPIX - 1) begin
                m_clear = 1'b0; m_k = 0;
            end else begin
                m_k++;
            end
        end else if (clear_req) begin
            m_clear = 1'b1; m_k = 0; ep = 1'b0;
        end else if (gi >= 0) begin
            ep = 1'b1;
            ex = int'(req_x[gi*X_W +: X_W]);
            ey = int'(req_y[gi*Y_W +: Y_W]);
            ec = int'(req_col[gi*COL_W +: COL_W]);
            m_ptr = gi;
        end else begin
            ep = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Counts busy cycles from the current one until the engine releases the port.
    task automatic wait_clear(output int cnt, output int dcnt, output int didx);
        cnt = 0; dcnt = 0; didx = -1;
        for (int n = 0; n < NPIX + 10; n++) begin
            #1;
            if (!clear_busy) return;
            cnt++;
            if (clear_done) begin
                dcnt++;
                didx = cnt;
            end
            step();
        end
        check("clear_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int cnt, dcnt, didx;
        rst = 1'b1; clear_req = 1'b0; req = 3'b000;
        req_x = '0; req_y = '0; req_col = '0;
        step(); step();
        #1;
        check("rst_plot", {31'd0, plot}, 0);
        check("rst_x", {24'd0, plot_x}, 0);
        check("rst_y", {25'd0, plot_y}, 0);
        check("rst_col", {29'd0, plot_col}, 0);
        check("rst_busy", {31'd0, clear_busy}, 0);
        check("rst_done", {31'd0, clear_done}, 0);
        check("rst_gnt", {29'd0, gnt}, 0);
        step();

        // Single head pixel.
        rst = 1'b0; req = 3'b010;
        req_x[1*X_W +: X_W] = 8'd5; req_y[1*Y_W +: Y_W] = 7'd7; req_col[1*COL_W +: COL_W] = 3'd2;
        #1 check("t1_gnt", {29'd0, gnt}, 32'b010);
        step(); req = 3'b000;
        #1;
        check("t1_plot", {31'd0, plot}, 1);
        check("t1_x", {24'd0, plot_x}, 5);
        check("t1_y", {25'd0, plot_y}, 7);
        check("t1_col", {29'd0, plot_col}, 2);
        step();
        #1 check("t1_idle", {31'd0, plot}, 0);
        step();

        // All three requesting from reset: 0,1,2,0,1,2.
        do_reset();
        req_x = 24'h30_20_10; req_y = 21'h0; req_col = 9'o321;
        req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1 check("t2_gnt", {29'd0, gnt}, 32'd1 << (c % 3));
            if (c > 0) check("t2_plot", {31'd0, plot}, 1);
            step();
        end
        req = 3'b000;
        #1 check("t2_last", {31'd0, plot}, 1);
        step();

        // After granting 2, requester 0 is next.
        do_reset();
        req = 3'b100;
        #1 check("t6_g2", {29'd0, gnt}, 32'b100);
        step();
        req = 3'b101;
        #1 check("t6_g0", {29'd0, gnt}, 32'b001);
        step();
        req = 3'b000;
        step();

        // Full clear with tail-erase held.
        req = 3'b001; req_x[0 +: X_W] = 8'd77; clear_req = 1'b1;
        #1 check("t3_nognt", {29'd0, gnt}, 0);
        step();
        clear_req = 1'b0;
        wait_clear(cnt, dcnt, didx);
        check("t3_busy_cycles", cnt, NPIX);
        check("t3_done_count", dcnt, 1);
        check("t3_done_last", didx, NPIX);
        check("t3_gnt_after", {29'd0, gnt}, 32'b001);
        check("t3_last_x", {24'd0, plot_x}, SW - 1);
        check("t3_last_y", {25'd0, plot_y}, SH - 1);
        step();
        req = 3'b000;
        step();

        // Reset in the middle of a clear at pixel (40,3).
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (3 * SW + 40) step();
        #1;
        check("t5_busy", {31'd0, clear_busy}, 1);
        check("t5_prev_x", {24'd0, plot_x}, 39);
        check("t5_prev_y", {25'd0, plot_y}, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_plot", {31'd0, plot}, 0);
        check("t5_busy_off", {31'd0, clear_busy}, 0);

        // Clear and food request together: clear first, food after.
        req = 3'b100; req_x[2*X_W +: X_W] = 8'd99; clear_req = 1'b1;
        #1 check("t4_nognt", {29'd0, gnt}, 0);
        step();
        clear_req = 1'b0;
        step();
        #1;
        check("t5_restart_x", {24'd0, plot_x}, 0);
        check("t5_restart_y", {25'd0, plot_y}, 0);
        check("t5_restart_plot", {31'd0, plot}, 1);
        wait_clear(cnt, dcnt, didx);
        check("t4_busy_cycles", cnt, NPIX - 1);
        check("t4_done_count", dcnt, 1);
        check("t4_food_gnt", {29'd0, gnt}, 32'b100);
        step();
        req = 3'b000;
        #1;
        check("t4_food_plot", {31'd0, plot}, 1);
        check("t4_food_x", {24'd0, plot_x}, 99);
        step();

        // Random requesters obeying the hold-until-granted handshake.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || m_gnt[i]) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    req_x[i*X_W +: X_W]       = X_W'($urandom);
                    req_y[i*Y_W +: Y_W]       = Y_W'($urandom);
                    req_col[i*COL_W +: COL_W] = COL_W'($urandom);
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; req = 3'b000;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
